shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
- Sequential 16x16 unsigned shift-and-add multiplier, one add/shift iteration per multiplier bit.
- Small control FSM plus accumulator/shift-register datapath.
- Used as the multi-cycle integer multiply unit of the MIPS CPU.
- Start/Idle/Done handshake toward the issuing control logic.

Parameters:
- WIDTH, 16, operand width; product is 2*WIDTH bits; all values below assume 16.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- St  in  1  start request, level-sensitive, sampled only in IDLE.
- Multiplicando  in  16  unsigned multiplicand, captured at LOAD.
- Multiplicador  in  16  unsigned multiplier, captured at LOAD.
- Produto  out  32  unsigned product; valid from DONE until the next LOAD.
- Idle  out  1  high while FSM is in IDLE.
- Done  out  1  one-cycle pulse, high while FSM is in DONE.

Behaviour:
- Interface: one clock (Clk); reset is synchronous and active-low (Reset).
- Reset (Reset=0 at a rising edge):
  - FSM to IDLE.
  - Accumulator A, register Q, counter and multiplicand register cleared.
  - Produto=0, Idle=1, Done=0.
  - Overrides any state, including mid-operation; a partial result is discarded.
- Datapath registers:
  - A: 17 bits = carry + high half.
  - Q: 16 bits, multiplier, becomes the low half.
  - M: 16 bits, multiplicand.
  - K: 4-bit iteration counter.
  - Produto = {A[15:0], Q} at all times.
- States: IDLE, LOAD, ADD, SHIFT, DONE.
- IDLE: Idle=1. St=1 -> LOAD; else stay.
- LOAD (1 cycle): M<=Multiplicando, Q<=Multiplicador, A<=0, K<=0 -> ADD.
- ADD (1 cycle): if Q[0]=1 then A <= {1'b0,A[15:0]} + M (17-bit sum, carry kept in A[16]); else hold. -> SHIFT.
- SHIFT (1 cycle): {A,Q} <= {1'b0, A, Q[15:1]}; K<=K+1.
  - If K was 15 (16th shift) -> DONE; else -> ADD.
- DONE (1 cycle): Done=1, registers hold -> IDLE unconditionally.
- Latency:
  - St sampled at edge E0; LOAD during cycle after E0.
  - 32 ADD/SHIFT cycles follow.
  - Done high during the cycle following edge E33.
  - Idle returns high after edge E34.
  - Back-to-back period with St held high: 35 cycles.
- Result and operand stability:
  - Produto holds the final result through DONE and IDLE until the next LOAD.
  - Operand changes after LOAD do not affect the current operation.
- No overflow: max 65535*65535 = 4294836225 fits in 32 bits. The carry in A[16] is always shifted down, never lost.
- St is ignored outside IDLE; deasserting St mid-operation has no effect.

Decomposition:
- Shared package holds:
  - WIDTH constant.
  - State enum typedef (IDLE, LOAD, ADD, SHIFT, DONE).
  - Counter terminal value WIDTH-1.
- One natural sub-module: shift_add_multiplier_ctrl (FSM).
  - Drives load, add, shift and k_done-consumption strobes.
  - Datapath stays in the top.

Test Plan:
- Reset=0 for 1 cycle then 1, St=0 -> Idle=1, Done=0, Produto=0, FSM stays IDLE indefinitely.
- 65535 x 65535, St pulse -> Done high exactly 33 cycles after the sampling edge; Produto=4294836225 (0xFFFE0001).
- 3 x 5 -> Produto=15; 0 x 65535 -> 0; 65535 x 1 -> 65535; 1 x 0 -> 0.
- St held at 1, operands changed between runs (sweep multiplier 0..65535, multiplicand fixed) -> each Done pulse shows the correct product; period 35 cycles; Done is one cycle wide.
- Reset=0 asserted at iteration 8 of 40000 x 40000 -> next cycle IDLE, Produto=0, Done=0; a new run then gives 1600000000.
- Operands changed after LOAD mid-run -> result uses the operands captured at LOAD.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// ----------------------------------------------------------------------------
// shift_add_multiplier_pkg
//   Shared constants and types for the sequential shift-and-add multiplier.
//   WIDTH   : operand width (product is 2*WIDTH bits)
//   CNT_W   : width of the iteration counter K
//   K_LAST  : counter value seen during the final (WIDTH-th) shift
//   state_t : control FSM state encoding
// ----------------------------------------------------------------------------
package shift_add_multiplier_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_ctrl.sv
// ----------------------------------------------------------------------------
// shift_add_multiplier_ctrl
//   Control FSM for the shift-and-add multiplier. Sequence:
//   IDLE -(St)-> LOAD -> {ADD -> SHIFT} x WIDTH -> DONE -> IDLE.
//   All outputs are registered and are high exactly while the FSM sits in
//   the matching state.
// Ports:
//   Clk       in   rising-edge clock
//   Reset     in   synchronous active-low reset
//   st_i      in   start request, only looked at in IDLE
//   k_done_i  in   iteration counter holds its last value (final shift)
//   load_o    out  capture operands, clear accumulator and counter
//   add_o     out  conditional add of the multiplicand into the accumulator
//   shift_o   out  shift {A,Q} right, advance counter
//   idle_o    out  FSM in IDLE
//   done_o    out  FSM in DONE (one-cycle pulse)
// ----------------------------------------------------------------------------
module shift_add_multiplier_ctrl
  import shift_add_multiplier_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic st_i,
  input  logic k_done_i,
  output logic load_o,
  output logic add_o,
  output logic shift_o,
  output logic idle_o,
  output logic done_o
);

  state_t state_q;
  logic   load_q;
  logic   add_q;
  logic   shift_q;
  logic   idle_q;
  logic   done_q;

  // Each strobe is set together with the transition into its state, so the
  // registered outputs line up with the state register without decode logic.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      add_q   <= 1'b0;
      shift_q <= 1'b0;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      load_q  <= 1'b0;
      add_q   <= 1'b0;
      shift_q <= 1'b0;
      idle_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (st_i) begin
            state_q <= LOAD;
            load_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            idle_q  <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= ADD;
          add_q   <= 1'b1;
        end
        ADD: begin
          state_q <= SHIFT;
          shift_q <= 1'b1;
        end
        SHIFT: begin
          // k_done_i reflects K before this shift's increment.
          if (k_done_i) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ADD;
            add_q   <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          idle_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  assign load_o  = load_q;
  assign add_o   = add_q;
  assign shift_o = shift_q;
  assign idle_o  = idle_q;
  assign done_o  = done_q;

endmodule

// File: rtl/shift_add_multiplier.sv
// ----------------------------------------------------------------------------
// shift_add_multiplier
//   Sequential WIDTH x WIDTH unsigned shift-and-add multiplier used as the
//   multi-cycle integer multiply unit. One ADD and one SHIFT cycle per
//   multiplier bit; the product forms in {A[WIDTH-1:0], Q}.
// Ports:
//   Clk            in   rising-edge clock
//   Reset          in   synchronous active-low reset
//   St             in   start request, level-sensitive, sampled in IDLE
//   Multiplicando  in   unsigned multiplicand, captured at LOAD
//   Multiplicador  in   unsigned multiplier, captured at LOAD
//   Produto        out  unsigned product, valid from DONE until next LOAD
//   Idle           out  high while idle
//   Done           out  one-cycle completion pulse
// ----------------------------------------------------------------------------
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 St,
  input  logic [WIDTH-1:0]     Multiplicando,
  input  logic [WIDTH-1:0]     Multiplicador,
  output logic [2*WIDTH-1:0]   Produto,
  output logic                 Idle,
  output logic                 Done
);

  logic load;
  logic add;
  logic shift;
  logic k_done;

  // A carries one extra bit so the add never loses its carry; the carry is
  // moved into A[WIDTH-1] by the following shift.
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CNT_W-1:0] k_q, k_d;

  shift_add_multiplier_ctrl u_ctrl (
    .Clk      (Clk),
    .Reset    (Reset),
    .st_i     (St),
    .k_done_i (k_done),
    .load_o   (load),
    .add_o    (add),
    .shift_o  (shift),
    .idle_o   (Idle),
    .done_o   (Done)
  );

  assign k_done = (k_q == K_LAST);

  always_comb begin
    a_d = a_q;
    q_d = q_q;
    m_d = m_q;
    k_d = k_q;
    if (load) begin
      m_d = Multiplicando;
      q_d = Multiplicador;
      a_d = '0;
      k_d = '0;
    end else if (add) begin
      if (q_q[0]) begin
        a_d = {1'b0, a_q[WIDTH-1:0]} + {1'b0, m_q};
      end
    end else if (shift) begin
      // {A,Q} shifted right as one register; A[0] enters the top of Q.
      a_d = {1'b0, a_q[WIDTH:1]};
      q_d = {a_q[0], q_q[WIDTH-1:1]};
      k_d = k_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      a_q <= '0;
      q_q <= '0;
      m_q <= '0;
      k_q <= '0;
    end else begin
      a_q <= a_d;
      q_q <= q_d;
      m_q <= m_d;
      k_q <= k_d;
    end
  end

  assign Produto = {a_q[WIDTH-1:0], q_q};

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

  logic        Clk;
  logic        Reset;
  logic        St;
  logic [15:0] Multiplicando;
  logic [15:0] Multiplicador;
  logic [31:0] Produto;
  logic        Idle;
  logic        Done;

  int errors;
  int checks;

  shift_add_multiplier dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .St            (St),
    .Multiplicando (Multiplicando),
    .Multiplicador (Multiplicador),
    .Produto       (Produto),
    .Idle          (Idle),
    .Done          (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: plain arithmetic product of two unsigned 16-bit numbers.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  // Runs one multiplication started by a single St pulse. lat is the number
  // of rising edges after the St-sampling edge until Done is seen (0 if it
  // never arrives). When scramble is set, operands and St are disturbed
  // mid-run. done_after / idle_after are sampled one cycle after Done.
  task automatic do_mult(input logic [15:0] a, input logic [15:0] b, input bit scramble,
                         output logic [31:0] prod, output int lat,
                         output logic done_after, output logic idle_after);
    @(negedge Clk);
    Multiplicando = a;
    Multiplicador = b;
    St = 1'b1;
    @(posedge Clk);
    #1 St = 1'b0;
    lat = 0;
    prod = '0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (scramble && n == 2) begin
        Multiplicando = ~a;
        Multiplicador = ~b ^ 16'h5a5a;
        St = 1'b1;
      end
      if (scramble && n == 10) St = 1'b0;
      if (Done) begin
        lat = n;
        prod = Produto;
        break;
      end
    end
    @(posedge Clk);
    @(negedge Clk);
    done_after = Done;
    idle_after = Idle;
  endtask

  task automatic test_reset();
    St = 1'b0;
    Reset = 1'b0;
    Multiplicando = 16'h1234;
    Multiplicador = 16'h5678;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    checks++;
    if (Idle !== 1'b1 || Done !== 1'b0 || Produto !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: Idle=%b Done=%b Produto=%h, required Idle=1 Done=0 Produto=0",
               Idle, Done, Produto);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      checks++;
      if (Idle !== 1'b1 || Done !== 1'b0 || Produto !== 32'd0) begin
        errors++;
        $display("FAIL reset_idle_hold cycle %0d: Idle=%b Done=%b Produto=%h, required 1/0/0",
                 i, Idle, Done, Produto);
      end
    end
    $display("test_reset: idle hold done");
  endtask

  task automatic test_corners();
    logic [15:0] ta [5];
    logic [15:0] tb [5];
    logic [31:0] prod, exp;
    int lat;
    logic d_after, i_after;
    ta = '{16'hFFFF, 16'd3, 16'd0, 16'hFFFF, 16'd1};
    tb = '{16'hFFFF, 16'd5, 16'hFFFF, 16'd1, 16'd0};
    for (int i = 0; i < 5; i++) begin
      do_mult(ta[i], tb[i], 1'b0, prod, lat, d_after, i_after);
      exp = ref_mul(ta[i], tb[i]);
      $display("corner %0d x %0d -> %0d (latency %0d)", ta[i], tb[i], prod, lat);
      checks++;
      if (lat != 33) begin
        errors++;
        $display("FAIL corner_latency %0d: got %0d cycles, required 33", i, lat);
      end
      checks++;
      if (prod !== exp) begin
        errors++;
        $display("FAIL corner_product %0d x %0d: got %0d, required %0d", ta[i], tb[i], prod, exp);
      end
      checks++;
      if (d_after !== 1'b0 || i_after !== 1'b1) begin
        errors++;
        $display("FAIL corner_done_width %0d: Done=%b Idle=%b after pulse, required 0/1",
                 i, d_after, i_after);
      end
      checks++;
      if (Produto !== exp) begin
        errors++;
        $display("FAIL corner_hold_in_idle %0d: got %0d, required %0d", i, Produto, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic [31:0] prod, exp;
    int lat;
    logic d_after, i_after;
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      do_mult(a, b, 1'b0, prod, lat, d_after, i_after);
      exp = ref_mul(a, b);
      $display("random %0d x %0d -> %0d", a, b, prod);
      checks++;
      if (lat == 0 || prod !== exp) begin
        errors++;
        $display("FAIL random_product %0d x %0d: got %0d (lat %0d), required %0d",
                 a, b, prod, lat, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] mcand;
    logic [15:0] mlist [$];
    logic [15:0] cur;
    logic [31:0] exp;
    int cyc, last, got;
    mcand = 16'($urandom) | 16'h8001;
    mlist = '{16'd0, 16'd1, 16'd2, 16'h8000, 16'hFFFF, 16'h7FFF};
    for (int i = 0; i < 10; i++) mlist.push_back(16'($urandom));
    cyc = 0;
    last = 0;
    @(negedge Clk);
    Multiplicando = mcand;
    cur = mlist[0];
    Multiplicador = cur;
    St = 1'b1;
    for (int i = 0; i < mlist.size(); i++) begin
      got = 0;
      for (int n = 0; n < 100; n++) begin
        @(posedge Clk);
        cyc++;
        @(negedge Clk);
        if (Done) begin
          got = 1;
          break;
        end
      end
      checks++;
      if (got == 0) begin
        errors++;
        $display("FAIL b2b_timeout run %0d: no Done within 100 cycles, required a pulse", i);
        break;
      end
      exp = ref_mul(mcand, cur);
      $display("b2b run %0d: %0d x %0d -> %0d at cycle %0d", i, mcand, cur, Produto, cyc);
      checks++;
      if (Produto !== exp) begin
        errors++;
        $display("FAIL b2b_product run %0d: got %0d, required %0d", i, Produto, exp);
      end
      if (i > 0) begin
        checks++;
        if (cyc - last != 35) begin
          errors++;
          $display("FAIL b2b_period run %0d: got %0d cycles, required 35", i, cyc - last);
        end
      end
      last = cyc;
      if (i + 1 < mlist.size()) begin
        cur = mlist[i + 1];
        Multiplicador = cur;
      end else begin
        St = 1'b0;
      end
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
      checks++;
      if (Done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_done_width run %0d: Done=%b a cycle after pulse, required 0", i, Done);
      end
    end
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if (Idle !== 1'b1) begin
      errors++;
      $display("FAIL b2b_final_idle: Idle=%b, required 1", Idle);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] prod;
    int lat;
    logic d_after, i_after;
    @(negedge Clk);
    Multiplicando = 16'd40000;
    Multiplicador = 16'd40000;
    St = 1'b1;
    @(posedge Clk);
    #1 St = 1'b0;
    // LOAD, then eight ADD/SHIFT pairs, landing in iteration 8.
    repeat (17) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    checks++;
    if (Idle !== 1'b1 || Done !== 1'b0 || Produto !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_state: Idle=%b Done=%b Produto=%h, required 1/0/0",
               Idle, Done, Produto);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      checks++;
      if (Done !== 1'b0 || Idle !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset_stays_idle cycle %0d: Done=%b Idle=%b, required 0/1",
                 i, Done, Idle);
        break;
      end
    end
    do_mult(16'd40000, 16'd40000, 1'b0, prod, lat, d_after, i_after);
    $display("mid_reset rerun 40000 x 40000 -> %0d", prod);
    checks++;
    if (lat != 33 || prod !== 32'd1600000000) begin
      errors++;
      $display("FAIL mid_reset_rerun: got %0d (lat %0d), required 1600000000 (lat 33)", prod, lat);
    end
  endtask

  task automatic test_operand_change();
    logic [15:0] a, b;
    logic [31:0] prod, exp;
    int lat;
    logic d_after, i_after;
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      do_mult(a, b, 1'b1, prod, lat, d_after, i_after);
      exp = ref_mul(a, b);
      $display("operand_change %0d x %0d -> %0d (latency %0d)", a, b, prod, lat);
      checks++;
      if (lat != 33 || prod !== exp) begin
        errors++;
        $display("FAIL operand_change %0d x %0d: got %0d (lat %0d), required %0d (lat 33)",
                 a, b, prod, lat, exp);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    Reset = 1'b0;
    St = 1'b0;
    Multiplicando = '0;
    Multiplicador = '0;
    test_reset();
    test_corners();
    test_random();
    test_back_to_back();
    test_mid_reset();
    test_operand_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
